// File: rtl/oqpsk_shaper_if.sv
// Handshake bundle for oqpsk_shaper: chip-pair input side and DAC sample output side.
// slave = shaper side, master = producer/consumer side.
interface oqpsk_shaper_if;
  logic       in_valid;
  logic       chip_i;
  logic       chip_q;
  logic       pret;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] data_i_out;
  logic [4:0] data_q_out;

  modport slave (
    input  in_valid, chip_i, chip_q, out_ready,
    output pret, out_valid, data_i_out, data_q_out
  );

  modport master (
    output in_valid, chip_i, chip_q, out_ready,
    input  pret, out_valid, data_i_out, data_q_out
  );
endinterface

// File: rtl/oqpsk_shaper.sv
// OQPSK pulse shaper: 8 samples per chip pair, Q offset by half a chip, 5-bit signed I/Q.
// Define OQPSK_SHAPER_HALFSINE_EN for the half-sine pulse; otherwise the pulse is rectangular.
//
// state | meaning
// IDLE  | no burst; waits for a buffered pair
// RUN   | shaping cur_i/cur_q, ph = sample index within the pair
// TAIL  | burst ended; emitting the second half of the last Q pulse
module oqpsk_shaper (
  input  logic          clk,
  input  logic          resetn,
  oqpsk_shaper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

`ifdef OQPSK_SHAPER_HALFSINE_EN
  localparam logic [3:0] H_TAB [8] = '{4'd3, 4'd8, 4'd12, 4'd15, 4'd15, 4'd12, 4'd8, 4'd3};
`else
  localparam logic [3:0] H_TAB [8] = '{default: 4'd15};
`endif

  function automatic logic [4:0] signed_sample(input logic chip, input logic [3:0] mag);
    logic [4:0] mag5;
    mag5 = {1'b0, mag};
    return chip ? mag5 : (~mag5 + 5'd1);
  endfunction

  state_t     state, state_n;
  logic [2:0] ph, ph_n;
  logic       cur_i, cur_i_n;
  logic       cur_q, cur_q_n;
  logic       q_prev, q_prev_n;
  logic       q_prev_act, q_prev_act_n;
  logic       buf_full, buf_full_n;
  logic       buf_i, buf_q;
  logic       pret_r;
  logic       out_valid_r;
  logic [4:0] data_i_r, data_q_r;

  logic       accept;
  logic       consume;
  logic       adv;
  logic       sample_valid;
  logic [4:0] sample_i, sample_q;

  // The output register is the presented sample; the generator (state/ph) moves
  // on only when that register is reloaded, so everything freezes while the DAC stalls.
  assign accept = bus.in_valid && pret_r;
  assign adv    = !out_valid_r || bus.out_ready;

  always_comb begin
    sample_valid = 1'b0;
    sample_i     = '0;
    sample_q     = '0;
    case (state)
      RUN: begin
        sample_valid = 1'b1;
        sample_i     = signed_sample(cur_i, H_TAB[ph]);
        if (ph[2])
          sample_q = signed_sample(cur_q, H_TAB[{1'b0, ph[1:0]}]);
        else if (q_prev_act)
          sample_q = signed_sample(q_prev, H_TAB[{1'b1, ph[1:0]}]);
      end
      TAIL: begin
        sample_valid = 1'b1;
        sample_q     = signed_sample(q_prev, H_TAB[{1'b1, ph[1:0]}]);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n      = state;
    ph_n         = ph;
    cur_i_n      = cur_i;
    cur_q_n      = cur_q;
    q_prev_n     = q_prev;
    q_prev_act_n = q_prev_act;
    consume      = 1'b0;
    case (state)
      IDLE: begin
        if (buf_full) begin
          cur_i_n      = buf_i;
          cur_q_n      = buf_q;
          consume      = 1'b1;
          ph_n         = 3'd0;
          q_prev_act_n = 1'b0;
          state_n      = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          if (ph == 3'd7) begin
            q_prev_n = cur_q;
            ph_n     = 3'd0;
            if (buf_full) begin
              q_prev_act_n = 1'b1;
              cur_i_n      = buf_i;
              cur_q_n      = buf_q;
              consume      = 1'b1;
            end else begin
              state_n = TAIL;
            end
          end else begin
            ph_n = ph + 3'd1;
          end
        end
      end
      TAIL: begin
        if (adv) begin
          if (ph == 3'd3) begin
            ph_n    = 3'd0;
            state_n = IDLE;
          end else begin
            ph_n = ph + 3'd1;
          end
        end
      end
      default: begin
        ph_n    = 3'd0;
        state_n = IDLE;
      end
    endcase
  end

  // pret is 1 only when the buffer is empty, so accept and consume never coincide.
  always_comb begin
    buf_full_n = buf_full;
    if (consume)
      buf_full_n = 1'b0;
    else if (accept)
      buf_full_n = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      ph         <= 3'd0;
      cur_i      <= 1'b0;
      cur_q      <= 1'b0;
      q_prev     <= 1'b0;
      q_prev_act <= 1'b0;
      buf_full   <= 1'b0;
      buf_i      <= 1'b0;
      buf_q      <= 1'b0;
      pret_r     <= 1'b1;
    end else begin
      state      <= state_n;
      ph         <= ph_n;
      cur_i      <= cur_i_n;
      cur_q      <= cur_q_n;
      q_prev     <= q_prev_n;
      q_prev_act <= q_prev_act_n;
      buf_full   <= buf_full_n;
      pret_r     <= !buf_full_n;
      if (accept) begin
        buf_i <= bus.chip_i;
        buf_q <= bus.chip_q;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_r <= 1'b0;
      data_i_r    <= '0;
      data_q_r    <= '0;
    end else if (adv) begin
      out_valid_r <= sample_valid;
      data_i_r    <= sample_i;
      data_q_r    <= sample_q;
    end
  end

  assign bus.pret       = pret_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.data_i_out = data_i_r;
  assign bus.data_q_out = data_q_r;

endmodule

// File: doc/oqpsk_shaper.md
OQPSK_SHAPER -- requirements
Module: oqpsk_shaper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The ports SHALL be:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  chip pair offered.
- chip_i  in  1  even (I) chip; 1 = positive, 0 = negative.
- chip_q  in  1  odd (Q) chip; same mapping.
- pret  out  1  ready; pair accepted on edge with in_valid && pret.
- out_ready  in  1  DAC side accepts current sample.
- out_valid  out  1  data_i_out/data_q_out hold a valid sample.
- data_i_out  out  5  I sample, two's complement.
- data_q_out  out  5  Q sample, two's complement.
REQ-003 The block SHALL have no parameters; all constants are fixed as stated below.

Function
REQ-004 Pulse table H[0..7] SHALL be magnitudes 3, 8, 12, 15, 15, 12, 8, 3; sample = +H for chip 1, -H (two's complement) for chip 0.
REQ-005 A one-entry input buffer SHALL hold an accepted pair; pret = !buf_full, registered.
REQ-006 A 3-bit phase counter ph SHALL advance by 1 only on transfer (out_valid && out_ready); outputs, ph and state SHALL hold while out_ready = 0.
REQ-007 The FSM SHALL have states IDLE, RUN and TAIL.
REQ-008 IDLE: out_valid = 0 and both data outputs = 0. If buf_full, the next edge SHALL load cur_i/cur_q from the buffer, clear the buffer, set ph = 0, clear q_prev_act, and enter RUN.
REQ-009 RUN: out_valid = 1 and data_i_out = sgn(cur_i)*H[ph].
REQ-010 RUN, data_q_out: for ph 0..3 it SHALL be sgn(q_prev)*H[ph+4] if q_prev_act, else 0; for ph 4..7 it SHALL be sgn(cur_q)*H[ph-4]. This gives the half-chip Q offset.
REQ-011 RUN, transfer at ph = 7 with buf_full: the block SHALL set q_prev <= cur_q and q_prev_act <= 1, load the next pair, clear the buffer, set ph <= 0, and stay in RUN with no gap sample.
REQ-012 RUN, transfer at ph = 7 with the buffer empty: the block SHALL set q_prev <= cur_q and ph <= 0, and enter TAIL.
REQ-013 TAIL: out_valid = 1, data_i_out = 0, data_q_out = sgn(q_prev)*H[ph+4]; a transfer at ph = 3 SHALL return the block to IDLE.
REQ-014 A pair accepted during TAIL SHALL wait in the buffer until IDLE and then start a new burst (REQ-008).
REQ-015 Latency: first out_valid SHALL rise two edges after the accepting edge when the block is IDLE.
REQ-016 Outputs SHALL derive from registers only, with no combinational path from in_valid or out_ready.
REQ-017 Sustained throughput SHALL be one pair per 8 transfers; upstream sees pret low at most from acceptance until the ph = 7 consume edge.

Reset
REQ-018 While resetn = 0 the block SHALL hold state IDLE, ph = 0, buffer empty, q_prev_act = 0, out_valid = 0, data outputs = 0, pret = 1.
REQ-019 Reset asserted mid-burst SHALL discard the buffered and in-progress chips; no tail SHALL be emitted after release.

Configuration
REQ-020 Macro OQPSK_SHAPER_HALFSINE_EN defined: table per REQ-004. Undefined: rectangular pulse, H[k] = 15 for all k; timing, FSM and offset unchanged.

Verification
REQ-021 Reset released, one pair (1,0) with out_ready = 1 -> 12 samples: I = 3,8,12,15,15,12,8,3,0,0,0,0; Q = 0,0,0,0,-3,-8,-12,-15,-15,-12,-8,-3; then IDLE.
REQ-022 Back-to-back pairs (1,1),(0,1) -> no out_valid gap; ph 0..3 of the second pair shows Q = 15,12,8,3 and I = -3,-8,-12,-15.
REQ-023 out_ready toggled 1/0 every cycle -> identical sample sequence to REQ-021; each sample held while out_ready = 0.
REQ-024 Second pair offered while buf_full -> pret = 0; pair accepted only after the ph = 7 consume edge; no chip lost or duplicated.
REQ-025 resetn pulsed low at ph = 5 of a burst -> out_valid = 0 and outputs 0 immediately; no tail samples after release.
REQ-026 Build without OQPSK_SHAPER_HALFSINE_EN, pair (0,1) -> I = -15 x8 then 0 x4; Q = 0 x4 then +15 x8.
